// File: rtl/arith_pkg.sv
// arith_pkg: opcodes, command packing and result width shared by the arithmetic command queue.
package arith_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam int RES_W = 32;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;
endpackage

// File: rtl/arith_cmd_fifo.sv
// arith_cmd_fifo: command storage with wrapping pointers, occupancy level and synchronous flush.
module arith_cmd_fifo
    import arith_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   wdata,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    cmd_t mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic do_push, do_pop;
    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem_q[rptr_q];
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
            rptr_d  = do_pop ? rptr_q + AW'(1) : rptr_q;
            level_d = level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/arith_cmd_queue.sv
// arith_cmd_queue: buffers arithmetic commands and registers results over valid/ready.
// Define ARITH_CMD_QUEUE_STATS_EN to add the done_cnt/err_cnt statistics outputs.
module arith_cmd_queue
    import arith_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   s00_axi_aclk,
    input  logic                   s00_axi_aresetn,
    input  logic                   flush,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [15:0]            cmd_a,
    input  logic [15:0]            cmd_b,
    input  logic [1:0]             cmd_op,
    output logic [15:0]            arith_a,
    output logic [15:0]            arith_b,
    output logic [1:0]             arith_op,
    input  logic [RES_W-1:0]       arith_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RES_W-1:0]       rsp_data,
    output logic [1:0]             rsp_op,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] level
`ifdef ARITH_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]            done_cnt,
    output logic [7:0]             err_cnt
`endif
);
    cmd_t head;
    logic full, empty, pop, rsv;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_op_q, rsp_op_d;
    arith_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .flush (flush),
        .push  (cmd_valid && cmd_ready),
        .pop   (pop),
        .wdata ('{a: cmd_a, b: cmd_b, op: cmd_op}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    assign cmd_ready = !full;
    assign arith_a   = head.a;
    assign arith_b   = head.b;
    assign arith_op  = head.op;
    assign pop       = !empty && (!rsp_valid_q || rsp_ready) && !flush;
    assign rsv       = head.op == OP_RSV;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        if (flush) begin
            rsp_valid_d = 1'b0;
            rsp_data_d  = '0;
            rsp_op_d    = '0;
            rsp_err_d   = 1'b0;
        end else if (pop) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rsv ? '0 : arith_c;
            rsp_op_d    = head.op;
            rsp_err_d   = rsv;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
`ifdef ARITH_CMD_QUEUE_STATS_EN
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    assign done_cnt = done_cnt_q;
    assign err_cnt  = err_cnt_q;
    always_comb begin
        done_cnt_d = done_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (flush) begin
            done_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (pop) begin
            done_cnt_d = done_cnt_q + 16'd1;
            err_cnt_d  = (rsv && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        end
    end
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_arith_cmd_queue.sv
// tb_arith_cmd_queue: scoreboard bench for arith_cmd_queue with a behavioural Arithmetic unit.
// Covers ARITH_CMD_QUEUE_STATS_EN counters when that macro is defined.
module tb_arith_cmd_queue;
    import arith_pkg::*;
    logic clk = 1'b0, rst_n, flush, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [15:0] cmd_a, cmd_b, arith_a, arith_b;
    logic [1:0] cmd_op, arith_op, rsp_op;
    logic [31:0] arith_c, rsp_data;
    logic [2:0] level;
`ifdef ARITH_CMD_QUEUE_STATS_EN
    logic [15:0] done_cnt;
    logic [7:0] err_cnt;
`endif
    typedef struct {
        logic [31:0] d;
        logic [1:0]  op;
        logic        e;
    } rsp_t;
    rsp_t exp_q[$];
    int rsp_cyc[$];
    int checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Arithmetic unit model; reserved opcode returns garbage so misuse shows up
    always_comb begin
        case (arith_op)
            OP_ADD:  arith_c = 32'($signed(arith_a)) + 32'($signed(arith_b));
            OP_SUB:  arith_c = 32'($signed(arith_a)) - 32'($signed(arith_b));
            OP_MUL:  arith_c = 32'($signed(arith_a)) * 32'($signed(arith_b));
            default: arith_c = 32'hDEADBEEF;
        endcase
    end

    arith_cmd_queue #(.DEPTH(4)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .flush           (flush),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_a           (cmd_a),
        .cmd_b           (cmd_b),
        .cmd_op          (cmd_op),
        .arith_a         (arith_a),
        .arith_b         (arith_b),
        .arith_op        (arith_op),
        .arith_c         (arith_c),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_op          (rsp_op),
        .rsp_err         (rsp_err),
        .level           (level)
`ifdef ARITH_CMD_QUEUE_STATS_EN
        ,
        .done_cnt        (done_cnt),
        .err_cnt         (err_cnt)
`endif
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_rsp_op_err"}, {29'd0, rsp_op, rsp_err}, 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_arith"}, {arith_a, arith_b[13:0], arith_op}, 32'd0);
        chk({tag, "_arith_b_hi"}, 32'(arith_b[15:14]), 32'd0);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [31:0] d, input logic e);
        int n = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=cmd_ready_low expected=accept");
        end else begin
            exp_q.push_back('{d: d, op: op, e: e});
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_five;
        push(16'd1, 16'd2, OP_ADD, 32'd3, 1'b0);
        push(16'd10, 16'd3, OP_SUB, 32'd7, 1'b0);
        push(16'hFFFE, 16'd3, OP_MUL, 32'hFFFFFFFA, 1'b0);
        push(16'd100, 16'hFF9C, OP_ADD, 32'd0, 1'b0);
        push(16'd7, 16'd7, OP_MUL, 32'd49, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=%h expected=none", rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_err", 32'(rsp_err), 32'(e.e));
                rsp_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        push(16'd1, 16'd1, OP_RSV, 32'd0, 1'b1);
        drain();
`ifdef ARITH_CMD_QUEUE_STATS_EN
        chk("done_cnt_rsv", 32'(done_cnt), 32'd1);
        chk("err_cnt_rsv", 32'(err_cnt), 32'd1);
`endif
        push(16'd3, 16'hFFFB, OP_ADD, 32'hFFFFFFFE, 1'b0);
        chk("lat_valid_early", 32'(rsp_valid), 32'd0);
        chk("lat_head", {arith_a, arith_b}, {16'd3, 16'hFFFB});
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(rsp_valid), 32'd1);
        drain();
        rsp_cyc.delete();
        push(16'hFED4, 16'h00C8, OP_MUL, 32'hFFFF15A0, 1'b0);
        push(16'h8000, 16'h0001, OP_SUB, 32'hFFFF7FFF, 1'b0);
        drain();
        chk("b2b_count", 32'(rsp_cyc.size()), 32'd2);
        if (rsp_cyc.size() == 2) chk("b2b_gap", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd1);
        rsp_ready = 1'b0;
        push_five();
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_head", {arith_a, arith_b[13:0], arith_op}, {16'd10, 14'd3, OP_SUB});
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_data", rsp_data, 32'd3);
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        drain();
        chk("bp_level_end", 32'(level), 32'd0);
        rsp_ready = 1'b0;
        push_five();
        cmd_a = 16'd9;
        cmd_b = 16'd9;
        cmd_op = OP_ADD;
        cmd_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        cmd_valid = 1'b0;
        exp_q.delete();
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_ready", 32'(cmd_ready), 32'd1);
        chk("flush_head", {arith_a, arith_b}, 32'd0);
`ifdef ARITH_CMD_QUEUE_STATS_EN
        chk("flush_done_cnt", 32'(done_cnt), 32'd0);
`endif
        rsp_ready = 1'b1;
        push(16'd2, 16'd3, OP_MUL, 32'd6, 1'b0);
        drain();
        chk("post_flush_level", 32'(level), 32'd0);
        rsp_ready = 1'b0;
        push(16'd4, 16'd5, OP_ADD, 32'd9, 1'b0);
        push(16'd6, 16'd1, OP_SUB, 32'd5, 1'b0);
        push(16'd2, 16'd2, OP_MUL, 32'd4, 1'b0);
        chk("rst_mid_level", 32'(level), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_after_valid", 32'(rsp_valid), 32'd0);
        chk("rst_after_level", 32'(level), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
